// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter: FSM state encoding,
// Avalon byte-enable pattern, data width and an index-width helper.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [3:0] FLASH_BE_ALL = 4'b1111;
    localparam int         FLASH_DATA_W = 32;

    // A single requester still needs a 1-bit index so no vector collapses to zero width.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first active request at or after the
// priority pointer, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idxWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int               cand;
    logic [IDX_W-1:0] candIdx;

    // Walk the requesters in priority order starting at the pointer; the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            candIdx = IDX_W'(cand);
            if (!valid_o && req_i[candIdx]) begin
                valid_o          = 1'b1;
                grant_o[candIdx] = 1'b1;
                idx_o            = candIdx;
            end
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one Avalon-MM flash read master among NUM_REQ requesters with
// round-robin fairness and a single read outstanding at a time.
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 23
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [FLASH_DATA_W-1:0]   rsp_data,
    output logic                      busy,
    output logic                      flash_mem_read,
    output logic [ADDR_W-1:0]         flash_mem_address,
    output logic [3:0]                flash_mem_byteenable,
    input  logic                      flash_mem_waitrequest,
    input  logic [FLASH_DATA_W-1:0]   flash_mem_readdata,
    input  logic                      flash_mem_readdatavalid
);

    localparam int IDX_W = idxWidth(NUM_REQ);

    state_t                  state_q;
    logic [IDX_W-1:0]        winner_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        ptr_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [FLASH_DATA_W-1:0] rspData_q;
    logic [NUM_REQ-1:0]      reqReady_q;
    logic [NUM_REQ-1:0]      rspValid_q;
    logic                    read_q;
    logic [3:0]              be_q;
    logic                    busy_q;

    logic [NUM_REQ-1:0]      arbGrant;
    logic [IDX_W-1:0]        arbIdx;
    logic                    arbValid;
    logic [NUM_REQ-1:0]      winnerOneHot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arbGrant),
        .idx_o   (arbIdx),
        .valid_o (arbValid)
    );

    // The requester just served drops to lowest priority once its response is out.
    always_comb begin
        ptr_d        = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
        winnerOneHot = NUM_REQ'(1) << winner_q;
    end

    // Every output is a register, so a reset mid-read drops the strobe in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            winner_q   <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            rspData_q  <= '0;
            reqReady_q <= '0;
            rspValid_q <= '0;
            read_q     <= 1'b0;
            be_q       <= 4'b0000;
            busy_q     <= 1'b0;
        end else begin
            reqReady_q <= '0;
            rspValid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arbValid) begin
                        winner_q   <= arbIdx;
                        addr_q     <= req_addr[arbIdx*ADDR_W +: ADDR_W];
                        reqReady_q <= arbGrant;
                        read_q     <= 1'b1;
                        be_q       <= FLASH_BE_ALL;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!flash_mem_waitrequest) begin
                        read_q  <= 1'b0;
                        be_q    <= 4'b0000;
                        state_q <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flash_mem_readdatavalid) begin
                        rspData_q  <= flash_mem_readdata;
                        rspValid_q <= winnerOneHot;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready            = reqReady_q;
    assign rsp_valid            = rspValid_q;
    assign rsp_data             = rspData_q;
    assign busy                 = busy_q;
    assign flash_mem_read       = read_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = be_q;

endmodule
